program_mem_arbiter: RTL
========================

PROGRAM_MEM_ARBITER -- requirements
Module: program_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, program-memory byte-address width (64 words).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, stall cycles before the first load write.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge. Reset is synchronous, active-low: reset_n.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port fetch_address  input  ADDR_WIDTH  fetch-stage byte address.
REQ-006 SHALL have port fetch_data  output  32  instruction returned to fetch.
REQ-007 SHALL have port load_start  input  1  pulse requesting a load session.
REQ-008 SHALL have port load_length  input  ADDR_WIDTH-1  word count, sampled with load_start.
REQ-009 SHALL have port load_valid / load_ready / load_data  input 1 / output 1 / input 32  word-stream handshake.
REQ-010 SHALL have port mem_address / mem_write_enable / mem_write_data  output ADDR_WIDTH / 1 / 32  program-memory side.
REQ-011 SHALL have port mem_read_data  input  32  program-memory read data.
REQ-012 SHALL have port cpu_stall / cpu_flush  output 1 / 1  pipeline hold, one-cycle pipeline-register clear.
REQ-013 SHALL have port busy / done / checksum  output 1 / 1 / 32  session active, completion pulse, load checksum.

Function
REQ-014 SHALL implement FSM states RUN, DRAIN, LOAD, FLUSH.
REQ-015 RUN: mem_address = fetch_address, mem_write_enable = 0, cpu_stall = 0, load_ready = 0.
REQ-016 fetch_data SHALL equal mem_read_data combinationally in all states; the block adds no read latency.
REQ-017 RUN with load_start=1 and load_length≠0 SHALL latch the length, clear the word pointer, and enter DRAIN next cycle.
REQ-018 load_length=0 SHALL be ignored. load_length above 2^(ADDR_WIDTH-2) SHALL clamp to 2^(ADDR_WIDTH-2).
REQ-019 load_start outside RUN SHALL be ignored.
REQ-020 DRAIN: cpu_stall=1, load_ready=0, count DRAIN_CYCLES cycles, then LOAD.
REQ-021 LOAD: cpu_stall=1, load_ready=1, mem_address = {ptr,2'b00}, mem_write_enable = load_valid, mem_write_data = load_data.
REQ-022 Each load_valid&&load_ready cycle SHALL write one word and increment ptr; no write SHALL occur without valid.
REQ-023 The handshake accepting word length-1 SHALL transition to FLUSH; ptr SHALL never wrap past the latched length.
REQ-024 FLUSH: exactly one cycle; cpu_stall=1, cpu_flush=1, load_ready=0; next state RUN with done=1 for that first RUN cycle.
REQ-025 busy SHALL be 1 in DRAIN, LOAD and FLUSH, otherwise 0.
REQ-026 All outputs except fetch_data and mem_address SHALL be driven from registered state only.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force RUN, clear ptr, drain counter, length and checksum, and deassert done.
REQ-028 During reset, cpu_stall, cpu_flush, load_ready, mem_write_enable and busy SHALL be 0.
REQ-029 Reset mid-LOAD SHALL abort the session without a flush pulse; words already written remain in memory.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: checksum SHALL be the modulo-2^32 sum of accepted words in the current session.
REQ-031 With LOADER_CHECKSUM_EN, the checksum SHALL be cleared on session start and held stable from done until the next session start.
REQ-032 Macro LOADER_CHECKSUM_EN undefined: checksum port SHALL remain present and tied to 0; no accumulator logic.

Structure
REQ-033 The arbiter_state_type enum (RUN, DRAIN, LOAD, FLUSH) SHALL live in package common.
REQ-034 The checksum accumulator SHALL be sub-module loader_checksum, instantiated only under LOADER_CHECKSUM_EN.
REQ-035 The FSM, counters and mux SHALL remain in program_mem_arbiter.

Verification
REQ-036 Reset then fetch_address=0x0C in RUN -> mem_address=0x0C, mem_write_enable=0, cpu_stall=0, busy=0.
REQ-037 load_start, load_length=3, words 0x11,0x22,0x33 back-to-back -> stall for 4 cycles, then writes at 0x00/0x04/0x08, 1 flush cycle, done; checksum=0x66 with macro, 0 without.
REQ-038 load_length=2 with load_valid gapped (1,0,0,1) -> exactly 2 writes, at 0x00 and 0x04; no write on idle cycles.
REQ-039 load_start with length 0, and load_start during LOAD -> state unchanged, no extra session.
REQ-040 reset_n=0 after 1 of 3 words -> RUN next cycle, cpu_flush never asserted, word at 0x00 retained.
REQ-041 load_length=100 with ADDR_WIDTH=8 -> 64 writes (0x00..0xFC), then FLUSH.

Source files
------------

// File: rtl/program_mem_arbiter_pkg.sv
// Shared types for the program-memory arbiter.
// The package is named "common" because other blocks share the arbiter state type.
package common;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        FLUSH = 2'd3
    } arbiter_state_type;

endpackage

// File: rtl/program_mem_arbiter_loader_checksum.sv
// Running modulo-2^32 sum of the words accepted during one load session.
// The sum is cleared when a session starts. Between sessions no words are accepted,
// so the sum stays at its final value after done.
module loader_checksum (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [31:0] word_i,
    output logic [31:0] sum_o
);

    logic [31:0] sum_q;
    logic [31:0] sum_d;

    // Next sum: a session start clears the sum; an accepted word adds to it.
    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (accept_i) begin
            sum_d = sum_q + word_i;
        end
    end

    // Accumulator register; cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/program_mem_arbiter.sv
// Program-memory arbiter.
// In normal operation, the fetch stage owns the program memory.
// A load session moves through these states:
//   1. It stalls the CPU for DRAIN_CYCLES cycles.
//   2. It streams load_length words into memory starting at address 0.
//   3. It pulses cpu_flush for one cycle.
//   4. It returns to RUN and pulses done.
// Optional feature: define LOADER_CHECKSUM_EN to compute a sum of the loaded words.
// Without that macro, checksum is tied to 0.
module program_mem_arbiter
    import common::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic [31:0]           fetch_data,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-2:0] load_length,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data,
    output logic                  cpu_stall,
    output logic                  cpu_flush,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           checksum
);

    // Lengths and pointers are one bit wider than a word index.
    // This lets them hold the full count 2^(ADDR_WIDTH-2).
    localparam int LEN_W = ADDR_WIDTH - 1;
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << IDX_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_ONE = DRN_W'(1);

    arbiter_state_type state_q, state_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [LEN_W-1:0]  ptr_q, ptr_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              done_q, done_d;

    logic start_accept;
    logic word_accept;
    logic last_word;

    function automatic logic [LEN_W-1:0] clamp_length(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    assign start_accept = (state_q == RUN) && load_start && (load_length != '0);
    assign word_accept  = (state_q == LOAD) && load_valid;
    assign last_word    = word_accept && (ptr_q == (length_q - LEN_ONE));

    // State register: reset always returns to RUN, which aborts any session without a flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the load session sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (start_accept) state_d = DRAIN;
            DRAIN:   if (drain_q == DRAIN_LAST) state_d = LOAD;
            LOAD:    if (last_word) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Counter and flag next values: latch the length, count the drain cycles, advance the word pointer.
    always_comb begin
        length_d = length_q;
        ptr_d    = ptr_q;
        drain_d  = drain_q;
        done_d   = (state_q == FLUSH);
        case (state_q)
            RUN: begin
                if (start_accept) begin
                    length_d = clamp_length(load_length);
                    ptr_d    = '0;
                    drain_d  = '0;
                end
            end
            DRAIN:   drain_d = drain_q + DRN_ONE;
            LOAD:    if (word_accept) ptr_d = ptr_q + LEN_ONE;
            default: ;
        endcase
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            length_q <= '0;
            ptr_q    <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            length_q <= length_d;
            ptr_q    <= ptr_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
        end
    end

    // Output decode from the state register.
    // Everything is held inactive while reset_n is low, so a reset mid-load cannot write a word.
    always_comb begin
        mem_address      = fetch_address;
        mem_write_enable = 1'b0;
        cpu_stall        = 1'b0;
        cpu_flush        = 1'b0;
        load_ready       = 1'b0;
        busy             = 1'b0;
        if (reset_n) begin
            case (state_q)
                DRAIN: begin
                    cpu_stall = 1'b1;
                    busy      = 1'b1;
                end
                LOAD: begin
                    cpu_stall        = 1'b1;
                    busy             = 1'b1;
                    load_ready       = 1'b1;
                    mem_address      = {ptr_q[IDX_W-1:0], 2'b00};
                    mem_write_enable = load_valid;
                end
                FLUSH: begin
                    cpu_stall = 1'b1;
                    cpu_flush = 1'b1;
                    busy      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_write_data = load_data;
    assign fetch_data     = mem_read_data;
    assign done           = done_q;

`ifdef LOADER_CHECKSUM_EN
    loader_checksum u_checksum (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (start_accept),
        .accept_i (word_accept),
        .word_i   (load_data),
        .sum_o    (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule
